// File: rtl/led_pattern_engine.sv
// LED pattern engine: rotate/ping-pong/flash at a selectable step rate.
// Optional ping-pong FSM is built when PATTERN_PINGPONG_EN is defined.
module led_pattern_engine #(
   parameter int N_LEDS     = 4,
   parameter int NB_COUNTER = 16,
   parameter int NB_SPEED   = 2,
   parameter int BASE_LIMIT = 256
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic [NB_SPEED-1:0] i_speed,
   input  logic [1:0]          i_mode,
   input  logic [1:0]          i_color,
   output logic [N_LEDS-1:0]   o_led,
   output logic [N_LEDS-1:0]   o_led_b,
   output logic [N_LEDS-1:0]   o_led_g,
   output logic [N_LEDS-1:0]   o_led_r,
   output logic                o_tick,
   output logic                o_cycle
);

   localparam logic [N_LEDS-1:0]     PAT_ONE = N_LEDS'(1);
   localparam logic [N_LEDS-1:0]     PAT_ALL = '1;
   localparam logic [NB_COUNTER-1:0] BASE    = NB_COUNTER'(BASE_LIMIT);
   localparam logic [NB_COUNTER-1:0] ONE_CNT = NB_COUNTER'(1);

   logic [NB_COUNTER-1:0] count_q;
   logic [NB_COUNTER-1:0] limit;
   logic [N_LEDS-1:0]     pat_q;
   logic [N_LEDS-1:0]     pat_d;
   logic [1:0]            mode_q;
   logic [1:0]            color_q;
   logic                  tick_q;
   logic                  cycle_q;
   logic                  cycle_d;
   logic                  mode_chg;
   logic                  step;

   assign limit    = BASE << i_speed;
   assign mode_chg = (i_mode != mode_q);
   // >= lets a switch to a shorter period step on the next enabled cycle
   assign step     = i_enable && !mode_chg && (count_q >= limit - ONE_CNT);

`ifdef PATTERN_PINGPONG_EN
   typedef enum logic {UP, DOWN} pp_state_t;
   pp_state_t state_q;
   pp_state_t state_d;

   // Ping-pong direction register
   always_ff @(posedge clock) begin
      if (i_reset) state_q <= UP;
      else         state_q <= state_d;
   end
`endif

   // Next pattern, ping-pong direction and cycle flag
   always_comb begin
      pat_d   = pat_q;
      cycle_d = 1'b0;
`ifdef PATTERN_PINGPONG_EN
      state_d = state_q;
`endif
      if (mode_chg) begin
         pat_d = (i_mode == 2'b11) ? PAT_ALL : PAT_ONE;
`ifdef PATTERN_PINGPONG_EN
         state_d = UP;
`endif
      end else if (step) begin
         unique case (mode_q)
            2'b01: begin
               pat_d   = {pat_q[0], pat_q[N_LEDS-1:1]};
               cycle_d = (pat_d == PAT_ONE);
            end
`ifdef PATTERN_PINGPONG_EN
            2'b10: begin
               if (state_q == UP) begin
                  pat_d = pat_q << 1;
                  if (pat_d[N_LEDS-1]) state_d = DOWN;
               end else begin
                  pat_d = pat_q >> 1;
                  if (pat_d[0]) begin
                     state_d = UP;
                     cycle_d = 1'b1;
                  end
               end
            end
`endif
            2'b11: begin
               pat_d   = ~pat_q;
               cycle_d = (pat_d == PAT_ALL);
            end
            default: begin
               pat_d   = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
               cycle_d = (pat_d == PAT_ONE);
            end
         endcase
      end
   end

   // Prescaler, pattern, colour and pulse registers
   always_ff @(posedge clock) begin
      if (i_reset) begin
         count_q <= '0;
         pat_q   <= PAT_ONE;
         mode_q  <= 2'b00;
         color_q <= 2'b00;
         tick_q  <= 1'b0;
         cycle_q <= 1'b0;
      end else begin
         mode_q  <= i_mode;
         pat_q   <= pat_d;
         tick_q  <= step;
         cycle_q <= cycle_d;
         if (mode_chg)      count_q <= '0;
         else if (step)     count_q <= '0;
         else if (i_enable) count_q <= count_q + ONE_CNT;
         if (step || !i_enable) color_q <= i_color;
      end
   end

   assign o_led   = pat_q;
   assign o_led_b = (color_q == 2'b00 || color_q == 2'b11) ? pat_q : '0;
   assign o_led_g = (color_q == 2'b01 || color_q == 2'b11) ? pat_q : '0;
   assign o_led_r = (color_q == 2'b10 || color_q == 2'b11) ? pat_q : '0;
   assign o_tick  = tick_q;
   assign o_cycle = cycle_q;

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator, successor to the board-level LED shifter top. Drives N_LEDS outputs with a selectable pattern (rotate left, rotate right, ping-pong, flash) at one of 2^NB_SPEED step rates. A colour select routes the pattern to blue, green, red or all channels. Colour changes take effect only on step boundaries, so a colour never changes mid-step. Sits directly under the board top, fed by debounced switches.

## Interface
- N_LEDS, 4, number of LEDs per colour channel; must be ≥ 2.
- NB_COUNTER, 16, width of the step prescaler counter.
- NB_SPEED, 2, width of the speed select.
- BASE_LIMIT, 256, step period in clocks at speed 0. Constraint: 1 ≤ BASE_LIMIT and BASE_LIMIT << (2^NB_SPEED−1) ≤ 2^NB_COUNTER−1.
- clock  in  1  single system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  1 = run; 0 = freeze counter and pattern.
- i_speed  in  NB_SPEED  step period = BASE_LIMIT << i_speed clocks.
- i_mode  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 flash.
- i_color  in  2  00 blue, 01 green, 10 red, 11 white (all three).
- o_led  out  N_LEDS  raw pattern.
- o_led_b  out  N_LEDS  pattern gated to blue.
- o_led_g  out  N_LEDS  pattern gated to green.
- o_led_r  out  N_LEDS  pattern gated to red.
- o_tick  out  1  one-cycle pulse, high in the cycle the new pattern first appears.
- o_cycle  out  1  one-cycle pulse with o_tick when the pattern returns to its mode's initial value.

## Operation
- Reset (priority over everything, also mid-operation):
  - count=0, pattern=0…01, ping-pong state=UP, color_q=00, mode_q=00.
  - Outputs: o_led=0…01, o_led_b=0…01, o_led_g=0, o_led_r=0, o_tick=0, o_cycle=0.
- Limit: limit = BASE_LIMIT << i_speed, computed at NB_COUNTER bits.
- Prescaler, when i_enable=1 and no mode change:
  - If count ≥ limit−1: step; count ← 0.
  - Otherwise count ← count+1.
  - The ≥ comparison handles a speed change to a shorter period: the step occurs on the next enabled cycle.
- Mode change (i_mode ≠ mode_q), regardless of i_enable:
  - mode_q ← i_mode, count ← 0, state ← UP.
  - pattern ← initial value: 1…1 for flash, 0…01 otherwise.
  - No step and no o_tick/o_cycle in that cycle.
- Step, by mode:
  - Rotate left: MSB wraps to LSB; o_cycle when the result is 0…01.
  - Rotate right: LSB wraps to MSB; o_cycle when the result is 0…01.
  - Ping-pong, FSM UP/DOWN:
    - UP shifts left; on reaching MSB, state ← DOWN.
    - DOWN shifts right; on reaching LSB, state ← UP and o_cycle.
  - Flash: pattern ← ~pattern; o_cycle when the result is 1…1.
- Colour: color_q ← i_color on every step, and on every cycle with i_enable=0. It is held otherwise.
- Channel gating:
  - o_led_b = pattern when color_q ∈ {00,11}, else 0.
  - o_led_g = pattern when color_q ∈ {01,11}, else 0.
  - o_led_r = pattern when color_q ∈ {10,11}, else 0.
- i_enable=0: count, pattern and state hold; o_tick and o_cycle stay 0.

## Timing
- count, pattern, state, color_q and o_tick/o_cycle are registers; channel outputs are AND-gating of registers only.
- Step period is exactly limit enabled clocks.
- After reset release with i_enable=1, the first pattern change appears limit cycles later.
- The new pattern, the new colour, o_tick and o_cycle all appear at the same clock edge.
- A mode change is visible one cycle after i_mode changes.
- A colour change while enabled is visible at the next step edge; while disabled, it is visible one cycle later.

## Configuration
- PATTERN_PINGPONG_EN defined: mode 10 is ping-pong as described.
- PATTERN_PINGPONG_EN undefined:
  - The UP/DOWN FSM is not built.
  - Mode 10 behaves exactly as rotate left, including o_cycle.
  - All other behaviour is unchanged.

## Test plan
All scenarios use N_LEDS=4 and BASE_LIMIT=4.
- Rotate left: reset, i_enable=1, i_speed=0, i_mode=00. o_led steps 0001→0010→0100→1000→0001, one step every 4 clocks. o_tick pulses on every step; o_cycle pulses only at 0001.
- Speed:
  - i_speed=2 gives a step every 16 clocks.
  - Start at i_speed=3, switch to i_speed=0 when count=20: step occurs on the next clock, then every 4 clocks.
- Ping-pong (macro defined): o_led sequence 0001,0010,0100,1000,0100,0010,0001; o_cycle at the final 0001. With macro undefined, mode 10 gives the rotate-left sequence.
- Colour:
  - i_color 00→01 at count=1 while enabled: o_led_b keeps the pattern until the next step, then o_led_g carries it and o_led_b=0.
  - i_color=11 drives all three channels equal to o_led.
- Mode change: in mode 00 at 0100, set i_mode=11. The next cycle shows o_led=1111 with no o_tick. Then 0000, then 1111 with o_cycle, every 4 clocks.
- Hold and reset:
  - i_enable=0 for 10 clocks: pattern and count frozen, no ticks.
  - i_reset=1 mid-step at 1000: the next cycle shows o_led=0001, o_led_b=0001, o_led_g=o_led_r=0.
